// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the logic-analyzer capture sequencer:
// command opcodes, sequencer state encodings and SET_TRIG field positions.
package capture_sequencer_pkg;

   localparam logic [2:0] LA_OP_NOP           = 3'd0;
   localparam logic [2:0] LA_OP_SET_TRIG      = 3'd1;
   localparam logic [2:0] LA_OP_SET_PRESCALER = 3'd2;
   localparam logic [2:0] LA_OP_SET_LIMIT     = 3'd3;
   localparam logic [2:0] LA_OP_ARM           = 3'd4;
   localparam logic [2:0] LA_OP_ABORT         = 3'd5;
   localparam logic [2:0] LA_OP_READOUT       = 3'd6;
   localparam logic [2:0] LA_OP_CLEAR         = 3'd7;

   localparam int LA_TRIG_START_SEL_LSB  = 0;
   localparam int LA_TRIG_END_SEL_LSB    = 3;
   localparam int LA_TRIG_START_EDGE_BIT = 6;
   localparam int LA_TRIG_END_EDGE_BIT   = 7;

   typedef enum logic [2:0] {
      LA_ST_IDLE    = 3'd0,
      LA_ST_ARMED   = 3'd1,
      LA_ST_CAPTURE = 3'd2,
      LA_ST_DONE    = 3'd3,
      LA_ST_RD_REQ  = 3'd4,
      LA_ST_RD_WAIT = 3'd5,
      LA_ST_RD_HOLD = 3'd6
   } la_state_e;

endpackage

// File: rtl/seq_cfg_regs.sv
// Configuration register file for the capture path: trigger selects,
// prescaler (zero clamped to one) and step limit with its enable.
module seq_cfg_regs
   import capture_sequencer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [2:0]       op_i,
   input  logic [CNT_W-1:0] arg_i,
   output logic [2:0]       trigStartSel_o,
   output logic [2:0]       trigEndSel_o,
   output logic             trigStartEdge_o,
   output logic             trigEndEdge_o,
   output logic [CNT_W-1:0] prescaler_o,
   output logic [CNT_W-1:0] stepLimit_o,
   output logic             doLimit_o
);

   logic [2:0]       trigStartSel_q;
   logic [2:0]       trigEndSel_q;
   logic             trigStartEdge_q;
   logic             trigEndEdge_q;
   logic [CNT_W-1:0] prescaler_q;
   logic [CNT_W-1:0] stepLimit_q;
   logic             doLimit_q;

   // Accepted SET_* commands load their field; a zero prescaler would stall the stepper so it is stored as one
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         trigStartSel_q  <= 3'd0;
         trigEndSel_q    <= 3'd1;
         trigStartEdge_q <= 1'b0;
         trigEndEdge_q   <= 1'b0;
         prescaler_q     <= CNT_W'(1);
         stepLimit_q     <= '0;
         doLimit_q       <= 1'b0;
      end else if (wr_en_i) begin
         if (op_i == LA_OP_SET_TRIG) begin
            trigStartSel_q  <= arg_i[LA_TRIG_START_SEL_LSB +: 3];
            trigEndSel_q    <= arg_i[LA_TRIG_END_SEL_LSB +: 3];
            trigStartEdge_q <= arg_i[LA_TRIG_START_EDGE_BIT];
            trigEndEdge_q   <= arg_i[LA_TRIG_END_EDGE_BIT];
         end
         if (op_i == LA_OP_SET_PRESCALER) begin
            prescaler_q <= (arg_i == '0) ? CNT_W'(1) : arg_i;
         end
         if (op_i == LA_OP_SET_LIMIT) begin
            stepLimit_q <= arg_i;
            doLimit_q   <= (arg_i != '0);
         end
      end
   end

   assign trigStartSel_o  = trigStartSel_q;
   assign trigEndSel_o    = trigEndSel_q;
   assign trigStartEdge_o = trigStartEdge_q;
   assign trigEndEdge_o   = trigEndEdge_q;
   assign prescaler_o     = prescaler_q;
   assign stepLimit_o     = stepLimit_q;
   assign doLimit_o       = doLimit_q;

endmodule

// File: rtl/capture_sequencer.sv
// Host-facing capture controller: command decode, acquisition sequencing
// (arm / capture / done), sample counting and FIFO drain to the host port.
module capture_sequencer
   import capture_sequencer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              i_clk,
   input  logic              _mrst,
   input  logic              i_cmd_valid,
   input  logic [2:0]        i_cmd_op,
   input  logic [CNT_W-1:0]  i_cmd_arg,
   output logic              o_cmd_err,
   output logic [2:0]        o_trig_start_select,
   output logic [2:0]        o_trig_end_select,
   output logic              o_trig_start_edge,
   output logic              o_trig_end_edge,
   output logic [CNT_W-1:0]  o_prescaler,
   output logic [CNT_W-1:0]  o_step_limit,
   output logic              o_do_limit,
   output logic              o_arm,
   output logic              o_fifo_clr,
   output logic              o_fifo_rdreq,
   input  logic              i_trig,
   input  logic              i_save,
   input  logic              i_limit_reached,
   input  logic              i_fifo_full,
   input  logic              i_fifo_empty,
   input  logic [DATA_W-1:0] i_fifo_q,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_rd_ready,
   output logic [2:0]        o_state,
   output logic              o_overflow,
   output logic [CNT_W-1:0]  o_sample_count
);

   la_state_e         state_q, state_d;
   logic              arm_q, arm_d;
   logic              fifoClr_q, fifoClr_d;
   logic              rdReq_q, rdReq_d;
   logic              rdValid_q, rdValid_d;
   logic              cmdErr_q, cmdErr_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  sampleCount_q, sampleCount_d;
   logic [DATA_W-1:0] rdData_q, rdData_d;
   logic              cfgState;
   logic              cfgWe;
   logic              isAbort;

   seq_cfg_regs #(
      .CNT_W(CNT_W)
   ) u_cfg (
      .clk_i           (i_clk),
      .rst_ni          (_mrst),
      .wr_en_i         (cfgWe),
      .op_i            (i_cmd_op),
      .arg_i           (i_cmd_arg),
      .trigStartSel_o  (o_trig_start_select),
      .trigEndSel_o    (o_trig_end_select),
      .trigStartEdge_o (o_trig_start_edge),
      .trigEndEdge_o   (o_trig_end_edge),
      .prescaler_o     (o_prescaler),
      .stepLimit_o     (o_step_limit),
      .doLimit_o       (o_do_limit)
   );

   // Command legality, next state and the registered strobes; ABORT outranks every datapath event
   always_comb begin
      state_d       = state_q;
      overflow_d    = overflow_q;
      sampleCount_d = sampleCount_q;
      rdData_d      = rdData_q;
      cmdErr_d      = 1'b0;
      fifoClr_d     = 1'b0;
      cfgState      = (state_q == LA_ST_IDLE) || (state_q == LA_ST_DONE);
      isAbort       = i_cmd_valid && (i_cmd_op == LA_OP_ABORT);
      cfgWe         = i_cmd_valid && cfgState;

      if (i_cmd_valid) begin
         if (i_cmd_op == LA_OP_ABORT) begin
            cmdErr_d = (state_q == LA_ST_IDLE);
         end else if (i_cmd_op != LA_OP_NOP) begin
            cmdErr_d = !cfgState;
         end
      end

      if (cfgWe && (i_cmd_op == LA_OP_CLEAR)) begin
         fifoClr_d     = 1'b1;
         overflow_d    = 1'b0;
         sampleCount_d = '0;
      end

      case (state_q)
         LA_ST_IDLE, LA_ST_DONE: begin
            if (cfgWe && (i_cmd_op == LA_OP_ARM)) begin
               fifoClr_d     = 1'b1;
               overflow_d    = 1'b0;
               sampleCount_d = '0;
               state_d       = LA_ST_ARMED;
            end else if ((state_q == LA_ST_DONE) && cfgWe &&
                         (i_cmd_op == LA_OP_READOUT) && !i_fifo_empty) begin
               state_d = LA_ST_RD_REQ;
            end
         end
         LA_ST_ARMED: begin
            if (isAbort) begin
               state_d = LA_ST_DONE;
            end else if (i_trig) begin
               state_d = LA_ST_CAPTURE;
            end
         end
         LA_ST_CAPTURE: begin
            if (isAbort) begin
               state_d = LA_ST_DONE;
            end else begin
               if (i_save && !i_fifo_full && (sampleCount_q != '1)) begin
                  sampleCount_d = sampleCount_q + CNT_W'(1);
               end
               if (i_fifo_full) begin
                  overflow_d = 1'b1;
               end
               if (!i_trig || i_limit_reached || i_fifo_full) begin
                  state_d = LA_ST_DONE;
               end
            end
         end
         LA_ST_RD_REQ: begin
            state_d = isAbort ? LA_ST_DONE : LA_ST_RD_WAIT;
         end
         LA_ST_RD_WAIT: begin
            if (isAbort) begin
               state_d = LA_ST_DONE;
            end else begin
               rdData_d = i_fifo_q;
               state_d  = LA_ST_RD_HOLD;
            end
         end
         LA_ST_RD_HOLD: begin
            if (isAbort) begin
               state_d = LA_ST_DONE;
            end else if (i_rd_ready) begin
               state_d = i_fifo_empty ? LA_ST_DONE : LA_ST_RD_REQ;
            end
         end
         default: begin
            state_d = LA_ST_IDLE;
         end
      endcase

      arm_d     = (state_d == LA_ST_ARMED) || (state_d == LA_ST_CAPTURE);
      rdReq_d   = (state_d == LA_ST_RD_REQ);
      rdValid_d = (state_d == LA_ST_RD_HOLD);
   end

   // State and output registers; reset drops o_arm at once, which also resets the datapath
   always_ff @(posedge i_clk or negedge _mrst) begin
      if (!_mrst) begin
         state_q       <= LA_ST_IDLE;
         arm_q         <= 1'b0;
         fifoClr_q     <= 1'b0;
         rdReq_q       <= 1'b0;
         rdValid_q     <= 1'b0;
         cmdErr_q      <= 1'b0;
         overflow_q    <= 1'b0;
         sampleCount_q <= '0;
         rdData_q      <= '0;
      end else begin
         state_q       <= state_d;
         arm_q         <= arm_d;
         fifoClr_q     <= fifoClr_d;
         rdReq_q       <= rdReq_d;
         rdValid_q     <= rdValid_d;
         cmdErr_q      <= cmdErr_d;
         overflow_q    <= overflow_d;
         sampleCount_q <= sampleCount_d;
         rdData_q      <= rdData_d;
      end
   end

   assign o_state        = state_q;
   assign o_arm          = arm_q;
   assign o_fifo_clr     = fifoClr_q;
   assign o_fifo_rdreq   = rdReq_q;
   assign o_rd_valid     = rdValid_q;
   assign o_cmd_err      = cmdErr_q;
   assign o_overflow     = overflow_q;
   assign o_sample_count = sampleCount_q;
   assign o_rd_data      = rdData_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed testbench for capture_sequencer: configuration, capture stop
// conditions, overflow, FIFO drain handshake, command errors and reset.
module tb_capture_sequencer;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 32;

   logic              i_clk;
   logic              _mrst;
   logic              i_cmd_valid;
   logic [2:0]        i_cmd_op;
   logic [CNT_W-1:0]  i_cmd_arg;
   logic              o_cmd_err;
   logic [2:0]        o_trig_start_select;
   logic [2:0]        o_trig_end_select;
   logic              o_trig_start_edge;
   logic              o_trig_end_edge;
   logic [CNT_W-1:0]  o_prescaler;
   logic [CNT_W-1:0]  o_step_limit;
   logic              o_do_limit;
   logic              o_arm;
   logic              o_fifo_clr;
   logic              o_fifo_rdreq;
   logic              i_trig;
   logic              i_save;
   logic              i_limit_reached;
   logic              i_fifo_full;
   logic              i_fifo_empty;
   logic [DATA_W-1:0] i_fifo_q;
   logic              o_rd_valid;
   logic [DATA_W-1:0] o_rd_data;
   logic              i_rd_ready;
   logic [2:0]        o_state;
   logic              o_overflow;
   logic [CNT_W-1:0]  o_sample_count;

   int compCount;
   int failCount;

   capture_sequencer #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .i_clk               (i_clk),
      ._mrst               (_mrst),
      .i_cmd_valid         (i_cmd_valid),
      .i_cmd_op            (i_cmd_op),
      .i_cmd_arg           (i_cmd_arg),
      .o_cmd_err           (o_cmd_err),
      .o_trig_start_select (o_trig_start_select),
      .o_trig_end_select   (o_trig_end_select),
      .o_trig_start_edge   (o_trig_start_edge),
      .o_trig_end_edge     (o_trig_end_edge),
      .o_prescaler         (o_prescaler),
      .o_step_limit        (o_step_limit),
      .o_do_limit          (o_do_limit),
      .o_arm               (o_arm),
      .o_fifo_clr          (o_fifo_clr),
      .o_fifo_rdreq        (o_fifo_rdreq),
      .i_trig              (i_trig),
      .i_save              (i_save),
      .i_limit_reached     (i_limit_reached),
      .i_fifo_full         (i_fifo_full),
      .i_fifo_empty        (i_fifo_empty),
      .i_fifo_q            (i_fifo_q),
      .o_rd_valid          (o_rd_valid),
      .o_rd_data           (o_rd_data),
      .i_rd_ready          (i_rd_ready),
      .o_state             (o_state),
      .o_overflow          (o_overflow),
      .o_sample_count      (o_sample_count)
   );

   // Free-running 10 ns clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance one cycle and settle just after the rising edge
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Present one command for exactly one cycle
   task automatic applyStimulus(input logic [2:0] op, input logic [CNT_W-1:0] arg);
      i_cmd_valid = 1'b1;
      i_cmd_op    = op;
      i_cmd_arg   = arg;
      tick();
      i_cmd_valid = 1'b0;
      i_cmd_op    = 3'd0;
      i_cmd_arg   = '0;
   endtask

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Directed sequence
   initial begin
      compCount       = 0;
      failCount       = 0;
      _mrst           = 1'b0;
      i_cmd_valid     = 1'b0;
      i_cmd_op        = 3'd0;
      i_cmd_arg       = '0;
      i_trig          = 1'b0;
      i_save          = 1'b0;
      i_limit_reached = 1'b0;
      i_fifo_full     = 1'b0;
      i_fifo_empty    = 1'b1;
      i_fifo_q        = '0;
      i_rd_ready      = 1'b0;

      tick();
      tick();
      checkOutput("rst_state", o_state, 0);
      checkOutput("rst_start_sel", o_trig_start_select, 0);
      checkOutput("rst_end_sel", o_trig_end_select, 1);
      checkOutput("rst_edges", {o_trig_start_edge, o_trig_end_edge}, 0);
      checkOutput("rst_prescaler", o_prescaler, 1);
      checkOutput("rst_limit", {o_do_limit, o_step_limit}, 0);
      checkOutput("rst_strobes", {o_arm, o_fifo_clr, o_fifo_rdreq, o_rd_valid, o_cmd_err}, 0);
      checkOutput("rst_ovf_cnt", {o_overflow, o_sample_count}, 0);
      checkOutput("rst_rd_data", o_rd_data, 0);
      _mrst = 1'b1;
      tick();

      $display("[TB] configuration writes");
      applyStimulus(3'd3, 32'd7);
      checkOutput("limit_val", o_step_limit, 7);
      checkOutput("limit_en", o_do_limit, 1);
      applyStimulus(3'd1, 32'd107);
      checkOutput("trig_sel", {o_trig_start_select, o_trig_end_select}, {3'd3, 3'd5});
      checkOutput("trig_edges", {o_trig_start_edge, o_trig_end_edge}, 2'b10);
      applyStimulus(3'd2, 32'd0);
      checkOutput("presc_clamp", o_prescaler, 1);
      applyStimulus(3'd2, 32'd10);
      checkOutput("presc_10", o_prescaler, 10);

      $display("[TB] capture stopped by step limit");
      applyStimulus(3'd4, 32'd0);
      checkOutput("arm_state", o_state, 1);
      checkOutput("arm_out", o_arm, 1);
      checkOutput("arm_clr", o_fifo_clr, 1);
      tick();
      checkOutput("clr_pulse_end", o_fifo_clr, 0);
      applyStimulus(3'd2, 32'd5);
      checkOutput("err_armed", o_cmd_err, 1);
      checkOutput("presc_kept", o_prescaler, 10);
      tick();
      checkOutput("err_pulse_end", o_cmd_err, 0);
      i_trig = 1'b1;
      tick();
      checkOutput("capture_state", o_state, 2);
      i_save = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      i_save = 1'b0;
      checkOutput("count_7", o_sample_count, 7);
      i_limit_reached = 1'b1;
      tick();
      i_limit_reached = 1'b0;
      i_trig = 1'b0;
      checkOutput("limit_done", o_state, 3);
      checkOutput("limit_arm_off", o_arm, 0);
      checkOutput("limit_count", o_sample_count, 7);

      $display("[TB] overflow with simultaneous limit");
      applyStimulus(3'd4, 32'd0);
      checkOutput("rearm_count", o_sample_count, 0);
      i_trig = 1'b1;
      tick();
      checkOutput("ovf_capture", o_state, 2);
      i_fifo_full     = 1'b1;
      i_limit_reached = 1'b1;
      i_save          = 1'b1;
      tick();
      i_fifo_full     = 1'b0;
      i_limit_reached = 1'b0;
      i_save          = 1'b0;
      i_trig          = 1'b0;
      checkOutput("ovf_done", o_state, 3);
      checkOutput("ovf_set", o_overflow, 1);
      checkOutput("ovf_no_count", o_sample_count, 0);
      applyStimulus(3'd7, 32'd0);
      checkOutput("clear_ovf", o_overflow, 0);
      checkOutput("clear_pulse", o_fifo_clr, 1);
      checkOutput("clear_state", o_state, 3);

      $display("[TB] readout of empty FIFO");
      applyStimulus(3'd6, 32'd0);
      checkOutput("ro_empty_state", o_state, 3);
      checkOutput("ro_empty_err", {o_cmd_err, o_fifo_rdreq}, 0);

      $display("[TB] drain three words with ready high");
      i_rd_ready   = 1'b1;
      i_fifo_empty = 1'b0;
      applyStimulus(3'd6, 32'd0);
      checkOutput("rA_req", {o_state, o_fifo_rdreq, o_rd_valid}, {3'd4, 1'b1, 1'b0});
      tick();
      i_fifo_q = 32'hA0A0_0001;
      checkOutput("rA_wait", {o_state, o_fifo_rdreq, o_rd_valid}, {3'd5, 1'b0, 1'b0});
      tick();
      i_fifo_q = 32'h5555_5555;
      checkOutput("rA_hold", {o_state, o_rd_valid}, {3'd6, 1'b1});
      checkOutput("rA_data", o_rd_data, 32'hA0A0_0001);
      tick();
      checkOutput("rB_req", {o_state, o_fifo_rdreq, o_rd_valid}, {3'd4, 1'b1, 1'b0});
      tick();
      i_fifo_q = 32'hB0B0_0002;
      checkOutput("rB_wait", {o_state, o_fifo_rdreq, o_rd_valid}, {3'd5, 1'b0, 1'b0});
      tick();
      i_fifo_q = 32'h5555_5555;
      checkOutput("rB_data", {o_rd_valid, o_rd_data}, {1'b1, 32'hB0B0_0002});
      tick();
      checkOutput("rC_req", {o_state, o_fifo_rdreq}, {3'd4, 1'b1});
      tick();
      i_fifo_q     = 32'hC0C0_0003;
      i_fifo_empty = 1'b1;
      checkOutput("rC_wait", {o_state, o_fifo_rdreq, o_rd_valid}, {3'd5, 1'b0, 1'b0});
      tick();
      i_fifo_q = 32'h5555_5555;
      checkOutput("rC_data", {o_rd_valid, o_rd_data}, {1'b1, 32'hC0C0_0003});
      tick();
      checkOutput("drain_done", {o_state, o_fifo_rdreq, o_rd_valid}, {3'd3, 1'b0, 1'b0});
      tick();
      checkOutput("drain_no_req", o_fifo_rdreq, 0);

      $display("[TB] hold with ready low, then abort");
      i_rd_ready   = 1'b0;
      i_fifo_empty = 1'b0;
      applyStimulus(3'd6, 32'd0);
      tick();
      i_fifo_q = 32'hDEAD_BEEF;
      tick();
      i_fifo_q = 32'h1234_5678;
      for (int i = 0; i < 10; i++) begin
         checkOutput("hold_cycle", {o_state, o_rd_valid, o_fifo_rdreq, o_rd_data},
                     {3'd6, 1'b1, 1'b0, 32'hDEAD_BEEF});
         tick();
      end
      applyStimulus(3'd5, 32'd0);
      checkOutput("hold_abort", {o_state, o_rd_valid, o_cmd_err}, {3'd3, 1'b0, 1'b0});
      i_fifo_empty = 1'b1;

      $display("[TB] abort while armed");
      applyStimulus(3'd4, 32'd0);
      applyStimulus(3'd5, 32'd0);
      checkOutput("armed_abort", {o_state, o_arm}, {3'd3, 1'b0});

      $display("[TB] asynchronous reset during capture");
      applyStimulus(3'd4, 32'd0);
      i_trig = 1'b1;
      tick();
      checkOutput("pre_rst_capture", {o_state, o_arm}, {3'd2, 1'b1});
      #2;
      _mrst = 1'b0;
      #1;
      checkOutput("async_rst_state", {o_state, o_arm}, {3'd0, 1'b0});
      checkOutput("async_rst_cfg", {o_prescaler, o_do_limit}, {32'd1, 1'b0});
      tick();
      i_trig = 1'b0;
      _mrst  = 1'b1;
      tick();

      $display("[TB] abort in idle is illegal");
      applyStimulus(3'd5, 32'd0);
      checkOutput("idle_abort_err", {o_cmd_err, o_state}, {1'b1, 3'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
      $finish;
   end

endmodule
